// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
// Used by dmem_array and data_memory_ctrl.
package dmem_pkg;

    typedef enum logic {
        DMEM_CLEAR = 1'b0,
        DMEM_IDLE  = 1'b1
    } dmem_state_e;

    // Widest word be_merge can handle; callers extend/truncate to it.
    localparam int DMEM_MAX_W = 256;

    function automatic logic [DMEM_MAX_W-1:0] be_merge(
        input logic [DMEM_MAX_W-1:0]   old_w,
        input logic [DMEM_MAX_W-1:0]   new_w,
        input logic [DMEM_MAX_W/8-1:0] be
    );
        logic [DMEM_MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < DMEM_MAX_W / 8; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data memory storage: one byte-enable write port, one registered
// read port and one combinational monitor read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IW     = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IW-1:0]          waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wbe,
    input  logic                   re,
    input  logic [IW-1:0]          raddr,
    output logic [DATA_W-1:0]      rdata,
    input  logic [IW-1:0]          mon_idx,
    output logic [DATA_W-1:0]      mon_word
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= DATA_W'(be_merge(DMEM_MAX_W'(mem[waddr]),
                                           DMEM_MAX_W'(wdata),
                                           (DMEM_MAX_W/8)'(wbe)));
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

    assign mon_word = mem[mon_idx];

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: valid/ready request port, response
// pulse, range check and clear sequencer. DMEM_STATS_EN adds counters.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_be,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    input  logic                   clr_req,
    output logic                   init_done,
    input  logic [ADDR_W-1:0]      mon_addr,
    output logic [DATA_W-1:0]      mon_data
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]            stat_rd,
    output logic [31:0]            stat_wr,
    output logic [31:0]            stat_err
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    dmem_state_e       state;
    logic [IW-1:0]     clr_ptr;
    logic              rd_sel;
    logic              acc;
    logic              in_range;
    logic              mon_in;
    logic              clr_we;
    logic              a_we;
    logic              a_re;
    logic [IW-1:0]     a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mon_word;

    assign in_range  = {1'b0, req_addr} < DEPTH_X;
    assign mon_in    = {1'b0, mon_addr} < DEPTH_X;
    assign req_ready = (state == DMEM_IDLE) && !clr_req && !reset;
    assign init_done = (state == DMEM_IDLE);
    assign acc       = req_valid && req_ready;

    // The clear sequencer owns the write port whenever it is running.
    assign clr_we  = (state == DMEM_CLEAR) && !reset;
    assign a_we    = clr_we || (acc && req_we && in_range);
    assign a_re    = acc && !req_we && in_range;
    assign a_waddr = clr_we ? clr_ptr : IW'(req_addr);
    assign a_wdata = clr_we ? '0 : req_wdata;
    assign a_be    = clr_we ? '1 : req_be;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .clk      (clk),
        .we       (a_we),
        .waddr    (a_waddr),
        .wdata    (a_wdata),
        .wbe      (a_be),
        .re       (a_re),
        .raddr    (IW'(req_addr)),
        .rdata    (rd_q),
        .mon_idx  (IW'(mon_addr)),
        .mon_word (mon_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DMEM_CLEAR;
            clr_ptr   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            rsp_valid <= acc;
            if (acc) begin
                rsp_err <= !in_range;
                rd_sel  <= !req_we && in_range;
            end
            unique case (state)
                DMEM_CLEAR: begin
                    if (clr_ptr == IW'(DEPTH - 1)) begin
                        state   <= DMEM_IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                DMEM_IDLE: begin
                    if (clr_req) begin
                        state   <= DMEM_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: state <= DMEM_CLEAR;
            endcase
        end
    end

    // Read data register only moves on reads; rd_sel zeroes write/error replies.
    assign rsp_rdata = rd_sel ? rd_q : '0;
    assign mon_data  = mon_in ? mon_word : '0;

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else if (acc) begin
            if (!in_range) begin
                if (stat_err != '1) stat_err <= stat_err + 1'b1;
            end else if (req_we) begin
                if (stat_wr != '1) stat_wr <= stat_wr + 1'b1;
            end else begin
                if (stat_rd != '1) stat_rd <= stat_rd + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (DEPTH=256, 16-bit words).
// Optional DMEM_STATS_EN counters are checked when the macro is defined.
module tb_data_memory_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        clr_req;
    logic        init_done;
    logic [15:0] mon_addr;
    logic [15:0] mon_data;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
    logic [31:0] stat_err;
`endif

    data_memory_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .clr_req   (clr_req),
        .init_done (init_done),
        .mon_addr  (mon_addr),
        .mon_data  (mon_data)
`ifdef DMEM_STATS_EN
        ,
        .stat_rd   (stat_rd),
        .stat_wr   (stat_wr),
        .stat_err  (stat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    endtask

    // Behavioural model: array contents, clear countdown, expected reply.
    logic [15:0] mdl [DEPTH];
    bit          known [DEPTH];
    int          clr_left = DEPTH;
    bit          started = 0;
    logic        e_rv = 0;
    logic [15:0] e_rd = 0;
    logic        e_err = 0;
    int          m_rd = 0;
    int          m_wr = 0;
    int          m_err = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            clr_left = DEPTH;
            e_rv = 0; e_rd = 0; e_err = 0;
            m_rd = 0; m_wr = 0; m_err = 0;
        end else if (clr_left > 0) begin
            mdl[DEPTH - clr_left] = 16'h0;
            known[DEPTH - clr_left] = 1;
            clr_left--;
            e_rv = 0;
        end else if (clr_req) begin
            clr_left = DEPTH;
            e_rv = 0;
        end else if (req_valid) begin
            e_rv = 1;
            if (int'(req_addr) >= DEPTH) begin
                e_err = 1; e_rd = 0; m_err++;
            end else if (req_we) begin
                if (req_be[0]) mdl[req_addr][7:0]  = req_wdata[7:0];
                if (req_be[1]) mdl[req_addr][15:8] = req_wdata[15:8];
                e_err = 0; e_rd = 0; m_wr++;
            end else begin
                e_rd = mdl[req_addr]; e_err = 0; m_rd++;
            end
        end else begin
            e_rv = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", req_ready, !reset && clr_left == 0 && !clr_req);
            chk("init_done", init_done, clr_left == 0);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_rdata", rsp_rdata, e_rd);
            chk("rsp_err", rsp_err, e_err);
            if (int'(mon_addr) >= DEPTH)
                chk("mon_oor", mon_data, 16'h0);
            else if (known[mon_addr])
                chk("mon_data", mon_data, mdl[mon_addr]);
`ifdef DMEM_STATS_EN
            chk("stat_rd", stat_rd, m_rd);
            chk("stat_wr", stat_wr, m_wr);
            chk("stat_err", stat_err, m_err);
`endif
        end
    end

    task automatic issue(input logic we, input int addr,
                         input logic [15:0] wd, input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = 16'(addr);
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_init(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!init_done && n < 2000);
        chk(name, n, exp_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; req_be = 0; clr_req = 0; mon_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_init", init_done, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        reset = 0;
        wait_init("init_len", 256);
        mon_addr = 0;
        #1 chk("mon0", mon_data, 16'h0000);
        mon_addr = 255;
        #1 chk("mon255", mon_data, 16'h0000);

        issue(1, 5, 16'hBEEF, 2'b11);
        chk("wr_rv", rsp_valid, 1);
        chk("wr_rdata", rsp_rdata, 0);
        issue(0, 5, 16'h0, 2'b00);
        chk("rd5_rv", rsp_valid, 1);
        chk("rd5_data", rsp_rdata, 16'hBEEF);
        chk("rd5_err", rsp_err, 0);
        issue(1, 5, 16'h1234, 2'b01);
        issue(0, 5, 16'h0, 2'b00);
        chk("merge", rsp_rdata, 16'hBE34);
        issue(1, 5, 16'hFFFF, 2'b00);
        chk("be0_rv", rsp_valid, 1);
        issue(0, 5, 16'h0, 2'b00);
        chk("be0_keep", rsp_rdata, 16'hBE34);

        mon_addr = 44;
        issue(1, 44, 16'h4444, 2'b11);
        issue(0, 300, 16'h0, 2'b00);
        chk("oor_rv", rsp_valid, 1);
        chk("oor_err", rsp_err, 1);
        chk("oor_rdata", rsp_rdata, 0);
        chk("oor_mon44", mon_data, 16'h4444);
        @(posedge clk);
        #1;
        chk("idle_rv", rsp_valid, 0);
        chk("hold_err", rsp_err, 1);

        for (int i = 0; i < 8; i++) begin
            issue(1, 100 + i, 16'(16'h1000 + i * 3), 2'b11);
            issue(0, 100 + i, 16'h0, 2'b00);
            chk("raw", rsp_rdata, 32'(16'h1000 + i * 3));
        end

        for (int i = 0; i < 60; i++) begin
            mon_addr  = 16'($urandom_range(0, 299));
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom_range(0, 299));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        req_valid = 0;
        mon_addr  = 5;

        clr_req = 1; req_valid = 1; req_we = 0; req_addr = 5;
        #1 chk("clr_ready", req_ready, 0);
        @(posedge clk);
        #1 clr_req = 0; req_valid = 0;
        chk("clr_norsp", rsp_valid, 0);
        repeat (10) @(posedge clk);
        #1 clr_req = 1;
        @(posedge clk);
        #1 clr_req = 0;
        wait_init("clr_len", 245);
        chk("clr_mon5", mon_data, 16'h0000);
        issue(0, 5, 16'h0, 2'b00);
        chk("clr_rd5", rsp_rdata, 16'h0000);

        clr_req = 1;
        @(posedge clk);
        #1 clr_req = 0;
        repeat (100) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        chk("rst_mid_init", init_done, 0);
        wait_init("rst_mid_len", 256);

`ifdef DMEM_STATS_EN
        issue(1, 1, 16'h0101, 2'b11);
        issue(0, 1, 16'h0, 2'b00);
        issue(1, 2, 16'h0202, 2'b10);
        issue(0, 2, 16'h0, 2'b00);
        issue(0, 400, 16'h0, 2'b00);
        issue(0, 3, 16'h0, 2'b00);
        #1;
        chk("lit_stat_rd", stat_rd, 3);
        chk("lit_stat_wr", stat_wr, 2);
        chk("lit_stat_err", stat_err, 1);
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
